// File: rtl/isp_restart_seq_if.sv
// TPSRAM port bundle between the restart sequencer (master) and the SRAM macro (slave).
interface isp_restart_seq_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 6
);
    logic [DATA_W-1:0] i_TPSRAM_RD_sv;
    logic [ADDR_W-1:0] o_TPSRAM_WADDR_sv;
    logic [ADDR_W-1:0] o_TPSRAM_RADDR_sv;
    logic [DATA_W-1:0] o_TPSRAM_WD;
    logic              o_TPSRAM_WEN;
    logic              o_TPSRAM_REN;

    modport master (
        input  i_TPSRAM_RD_sv,
        output o_TPSRAM_WADDR_sv, o_TPSRAM_RADDR_sv, o_TPSRAM_WD, o_TPSRAM_WEN, o_TPSRAM_REN
    );
    modport slave (
        output i_TPSRAM_RD_sv,
        input  o_TPSRAM_WADDR_sv, o_TPSRAM_RADDR_sv, o_TPSRAM_WD, o_TPSRAM_WEN, o_TPSRAM_REN
    );
endinterface

// File: rtl/isp_restart_seq.sv
// Post-ISP restart sequencer: classifies boot via an SRAM signature, rewrites it on
// cold boot and stretches the downstream reset; also services runtime restart requests.
module isp_restart_seq #(
    parameter int                DATA_W        = 8,
    parameter int                ADDR_W        = 6,
    parameter int                SIG_WORDS     = 4,
    parameter int                BASE_ADDR     = 60,
    parameter logic [DATA_W-1:0] SIG_SEED      = 'hA5,
    parameter int                RST_PULSE_CYC = 16
) (
    input  logic                 CLK,
    input  logic                 RESETn,
    input  logic                 i_restart_req,
    isp_restart_seq_if.master    ram,
    output logic                 o_reset_n,
    output logic                 o_busy,
    output logic                 o_cold_boot,
    output logic [7:0]           o_restart_cnt
);
    localparam int KW = (SIG_WORDS > 1) ? $clog2(SIG_WORDS) : 1;
    localparam int PW = (RST_PULSE_CYC > 1) ? $clog2(RST_PULSE_CYC) : 1;
    localparam logic [KW-1:0]     LAST   = KW'(SIG_WORDS - 1);
    localparam logic [PW-1:0]     P_LAST = PW'(RST_PULSE_CYC - 1);
    localparam logic [ADDR_W-1:0] BASE_A = ADDR_W'(BASE_ADDR);

    typedef enum logic [2:0] {IDLE, RD, CMP, WR_SIG, PULSE, RUN, CLR_SIG} state_t;

    state_t            state, state_nx;
    logic [KW-1:0]     k, k_nx, kp1;
    logic [PW-1:0]     pcnt, pcnt_nx;
    logic              wen, wen_nx, ren, ren_nx;
    logic [ADDR_W-1:0] waddr, waddr_nx, raddr, raddr_nx;
    logic [DATA_W-1:0] wd, wd_nx;
    logic              rst_q, rst_nx, busy_nx, cold, cold_nx;
    logic [7:0]        cnt, cnt_nx;

    function automatic logic [DATA_W-1:0] sig(input logic [KW-1:0] idx);
        return SIG_SEED ^ DATA_W'(idx);
    endfunction

    function automatic logic [ADDR_W-1:0] addr_of(input logic [KW-1:0] idx);
        return BASE_A + ADDR_W'(idx);
    endfunction

    assign kp1 = k + KW'(1);

    always_ff @(posedge CLK) begin
        if (!RESETn) begin
            state <= IDLE;
            k     <= '0;
            pcnt  <= '0;
            wen   <= 1'b0;
            ren   <= 1'b0;
            waddr <= BASE_A;
            raddr <= BASE_A;
            wd    <= '0;
            rst_q <= 1'b0;
            o_busy <= 1'b1;
            cold  <= 1'b0;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            k     <= k_nx;
            pcnt  <= pcnt_nx;
            wen   <= wen_nx;
            ren   <= ren_nx;
            waddr <= waddr_nx;
            raddr <= raddr_nx;
            wd    <= wd_nx;
            rst_q <= rst_nx;
            o_busy <= busy_nx;
            cold  <= cold_nx;
            cnt   <= cnt_nx;
        end
    end

    // Outputs are registered, so each state's strobes are launched on the edge entering it.
    always_comb begin
        state_nx = state;
        k_nx     = k;
        pcnt_nx  = pcnt;
        wen_nx   = 1'b0;
        ren_nx   = 1'b0;
        waddr_nx = waddr;
        raddr_nx = raddr;
        wd_nx    = wd;
        rst_nx   = 1'b0;
        cold_nx  = cold;
        cnt_nx   = cnt;
        case (state)
            IDLE: begin
                k_nx     = '0;
                ren_nx   = 1'b1;
                raddr_nx = BASE_A;
                state_nx = RD;
            end
            RD: state_nx = CMP;
            CMP: begin
                if (ram.i_TPSRAM_RD_sv != sig(k)) begin
                    // First rewrite goes out on this edge; the last word overlaps PULSE entry.
                    cold_nx  = 1'b1;
                    k_nx     = '0;
                    pcnt_nx  = '0;
                    wen_nx   = 1'b1;
                    waddr_nx = BASE_A;
                    wd_nx    = sig('0);
                    state_nx = (SIG_WORDS == 1) ? PULSE : WR_SIG;
                end else if (k != LAST) begin
                    k_nx     = kp1;
                    ren_nx   = 1'b1;
                    raddr_nx = addr_of(kp1);
                    state_nx = RD;
                end else begin
                    cold_nx  = 1'b0;
                    rst_nx   = 1'b1;
                    state_nx = RUN;
                end
            end
            WR_SIG: begin
                k_nx     = kp1;
                wen_nx   = 1'b1;
                waddr_nx = addr_of(kp1);
                wd_nx    = sig(kp1);
                if (kp1 == LAST) state_nx = PULSE;
            end
            PULSE: begin
                if (pcnt == P_LAST) begin
                    rst_nx   = 1'b1;
                    cnt_nx   = (cnt == 8'hFF) ? cnt : cnt + 8'd1;
                    state_nx = RUN;
                end else begin
                    pcnt_nx = pcnt + PW'(1);
                end
            end
            RUN: begin
                rst_nx = 1'b1;
                if (i_restart_req) begin
                    rst_nx   = 1'b0;
                    k_nx     = '0;
                    wen_nx   = 1'b1;
                    waddr_nx = BASE_A;
                    wd_nx    = '0;
                    state_nx = CLR_SIG;
                end
            end
            CLR_SIG: begin
                if (k == LAST) begin
                    k_nx     = '0;
                    state_nx = IDLE;
                end else begin
                    k_nx     = kp1;
                    wen_nx   = 1'b1;
                    waddr_nx = addr_of(kp1);
                    wd_nx    = '0;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign busy_nx = (state_nx != RUN);

    assign ram.o_TPSRAM_WEN      = wen;
    assign ram.o_TPSRAM_REN      = ren;
    assign ram.o_TPSRAM_WADDR_sv = waddr;
    assign ram.o_TPSRAM_RADDR_sv = raddr;
    assign ram.o_TPSRAM_WD       = wd;
    assign o_reset_n             = rst_q;
    assign o_cold_boot           = cold;
    assign o_restart_cnt         = cnt;
endmodule

// File: tb/tb_isp_restart_seq.sv
// Directed bench: instance A at default parameters, instance B at 16-bit/10-bit/8-word.
module tb_isp_restart_seq;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a = 1'b0, rst_b = 1'b0, req = 1'b0;
    bit   sel = 1'b0;
    int   n_chk = 0, n_bad = 0;

    isp_restart_seq_if #(.DATA_W(8),  .ADDR_W(6))  bus_a();
    isp_restart_seq_if #(.DATA_W(16), .ADDR_W(10)) bus_b();

    logic       rn_a, busy_a, cold_a, rn_b, busy_b, cold_b;
    logic [7:0] cnt_a, cnt_b;

    isp_restart_seq u_a (.CLK(clk), .RESETn(rst_a), .i_restart_req(req), .ram(bus_a.master),
        .o_reset_n(rn_a), .o_busy(busy_a), .o_cold_boot(cold_a), .o_restart_cnt(cnt_a));

    isp_restart_seq #(.DATA_W(16), .ADDR_W(10), .SIG_WORDS(8), .BASE_ADDR(60),
        .SIG_SEED(16'h00A5), .RST_PULSE_CYC(16)) u_b (.CLK(clk), .RESETn(rst_b),
        .i_restart_req(req), .ram(bus_b.master), .o_reset_n(rn_b), .o_busy(busy_b),
        .o_cold_boot(cold_b), .o_restart_cnt(cnt_b));

    initial begin
        assert (60 + 4 <= 64);
        assert (60 + 8 <= 1024);
    end

    // Behavioural TPSRAM models with a preload port and traffic counters.
    logic [7:0]  mem_a [0:63];
    logic [15:0] mem_b [0:1023];
    logic        pl_a = 1'b0, pl_b = 1'b0;
    int          pl_addr = 0, pl_data = 0;
    int          rdc_a = 0, wrc_a = 0, ovl_a = 0, rdc_b = 0, wrc_b = 0, ovl_b = 0;
    int          lra_a = 0, lra_b = 0;

    always @(posedge clk) begin
        if (pl_a) mem_a[pl_addr] <= 8'(pl_data);
        if (bus_a.o_TPSRAM_WEN) begin
            mem_a[bus_a.o_TPSRAM_WADDR_sv] <= bus_a.o_TPSRAM_WD;
            wrc_a <= wrc_a + 1;
        end
        if (bus_a.o_TPSRAM_REN) begin
            bus_a.i_TPSRAM_RD_sv <= mem_a[bus_a.o_TPSRAM_RADDR_sv];
            rdc_a <= rdc_a + 1;
            lra_a <= int'(bus_a.o_TPSRAM_RADDR_sv);
        end
        if (bus_a.o_TPSRAM_WEN && bus_a.o_TPSRAM_REN) ovl_a <= ovl_a + 1;
    end

    always @(posedge clk) begin
        if (pl_b) mem_b[pl_addr] <= 16'(pl_data);
        if (bus_b.o_TPSRAM_WEN) begin
            mem_b[bus_b.o_TPSRAM_WADDR_sv] <= bus_b.o_TPSRAM_WD;
            wrc_b <= wrc_b + 1;
        end
        if (bus_b.o_TPSRAM_REN) begin
            bus_b.i_TPSRAM_RD_sv <= mem_b[bus_b.o_TPSRAM_RADDR_sv];
            rdc_b <= rdc_b + 1;
            lra_b <= int'(bus_b.o_TPSRAM_RADDR_sv);
        end
        if (bus_b.o_TPSRAM_WEN && bus_b.o_TPSRAM_REN) ovl_b <= ovl_b + 1;
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int sw();       return sel ? 8 : 4;                 endfunction
    function automatic int sigv(int k); return 32'hA5 ^ k;                  endfunction
    function automatic int memv(int a); return sel ? int'(mem_b[a]) : int'(mem_a[a]); endfunction
    function automatic int rdc();      return sel ? rdc_b : rdc_a;         endfunction
    function automatic int wrc();      return sel ? wrc_b : wrc_a;         endfunction
    function automatic int o_rn();     return int'(sel ? rn_b : rn_a);     endfunction
    function automatic int o_busy();   return int'(sel ? busy_b : busy_a); endfunction
    function automatic int o_cold();   return int'(sel ? cold_b : cold_a); endfunction
    function automatic int o_cnt();    return int'(sel ? cnt_b : cnt_a);   endfunction
    function automatic int o_wen();    return int'(sel ? bus_b.o_TPSRAM_WEN : bus_a.o_TPSRAM_WEN); endfunction
    function automatic int o_ren();    return int'(sel ? bus_b.o_TPSRAM_REN : bus_a.o_TPSRAM_REN); endfunction
    function automatic int o_waddr();  return int'(sel ? bus_b.o_TPSRAM_WADDR_sv : 10'(bus_a.o_TPSRAM_WADDR_sv)); endfunction
    function automatic int o_raddr();  return int'(sel ? bus_b.o_TPSRAM_RADDR_sv : 10'(bus_a.o_TPSRAM_RADDR_sv)); endfunction
    function automatic int o_wd();     return int'(sel ? bus_b.o_TPSRAM_WD : 16'(bus_a.o_TPSRAM_WD)); endfunction

    task automatic set_rst(input bit v);
        if (sel) rst_b = v; else rst_a = v;
    endtask

    // mode 0: all zero, mode 1: valid signature with word 'bad' zeroed (bad<0: none)
    task automatic preload(input int mode, input int bad);
        for (int k = 0; k < sw(); k++) begin
            pl_addr = 60 + k;
            pl_data = (mode == 0 || k == bad) ? 0 : sigv(k);
            if (sel) pl_b = 1'b1; else pl_a = 1'b1;
            @(posedge clk);
            @(negedge clk);
            pl_a = 1'b0;
            pl_b = 1'b0;
        end
    endtask

    task automatic reset_and_load(input string tag, input int mode, input int bad);
        @(negedge clk);
        set_rst(1'b0);
        preload(mode, bad);
        chk({tag, ".rst_wen"},   o_wen(),   0);
        chk({tag, ".rst_ren"},   o_ren(),   0);
        chk({tag, ".rst_waddr"}, o_waddr(), 60);
        chk({tag, ".rst_raddr"}, o_raddr(), 60);
        chk({tag, ".rst_wd"},    o_wd(),    0);
        chk({tag, ".rst_rn"},    o_rn(),    0);
        chk({tag, ".rst_busy"},  o_busy(),  1);
        chk({tag, ".rst_cold"},  o_cold(),  0);
        chk({tag, ".rst_cnt"},   o_cnt(),   0);
    endtask

    // Called at a negedge; counts edges until o_reset_n is seen high, bounded.
    task automatic wait_rise(inout int n);
        for (int i = 0; i < 300; i++) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (o_rn() == 1) return;
        end
    endtask

    task automatic boot(input string tag, input int exp_lat);
        int n = 0;
        set_rst(1'b1);
        wait_rise(n);
        chk({tag, ".latency"}, n, exp_lat);
        req = 1'b0;
    endtask

    task automatic chk_sig(input string tag);
        for (int k = 0; k < sw(); k++) chk($sformatf("%s.mem%0d", tag, k), memv(60 + k), sigv(k));
    endtask

    int r0, w0, n;

    initial begin
        // 1: cold boot from zeroed RAM
        sel = 1'b0;
        reset_and_load("c1", 0, -1);
        r0 = rdc(); w0 = wrc();
        boot("c1", 22);
        chk("c1.reads", rdc() - r0, 1);
        chk("c1.last_raddr", lra_a, 60);
        chk("c1.writes", wrc() - w0, 4);
        chk_sig("c1");
        chk("c1.cold", o_cold(), 1);
        chk("c1.cnt", o_cnt(), 1);
        chk("c1.busy", o_busy(), 0);

        // 2: warm boot
        reset_and_load("w2", 1, -1);
        r0 = rdc(); w0 = wrc();
        boot("w2", 9);
        chk("w2.reads", rdc() - r0, 4);
        chk("w2.writes", wrc() - w0, 0);
        chk("w2.cold", o_cold(), 0);
        chk("w2.cnt", o_cnt(), 0);

        // 4 + 6: runtime restart, request held through CLR_SIG and the re-check
        r0 = rdc(); w0 = wrc();
        req = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("r4.rn_low", o_rn(), 0);
        chk("r4.busy", o_busy(), 1);
        chk("r4.clr_wen", o_wen(), 1);
        chk("r4.clr_wd", o_wd(), 0);
        n = 1;
        wait_rise(n);
        req = 1'b0;
        chk("r4.latency", n, 27);
        repeat (3) @(negedge clk);
        chk("r4.stay_run", o_rn(), 1);
        chk("r4.writes", wrc() - w0, 8);
        chk("r4.reads", rdc() - r0, 1);
        chk("r4.cnt", o_cnt(), 1);
        chk("r4.cold", o_cold(), 1);
        chk_sig("r4");

        // 3: word 2 corrupted
        reset_and_load("p3", 1, 2);
        r0 = rdc(); w0 = wrc();
        boot("p3", 26);
        chk("p3.reads", rdc() - r0, 3);
        chk("p3.last_raddr", lra_a, 62);
        chk("p3.writes", wrc() - w0, 4);
        chk_sig("p3");
        chk("p3.cold", o_cold(), 1);

        // 5: reset sampled on the edge that would launch the second write
        reset_and_load("m5", 0, -1);
        set_rst(1'b1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("m5.first_wen", o_wen(), 1);
        chk("m5.first_waddr", o_waddr(), 60);
        set_rst(1'b0);
        @(posedge clk);
        @(negedge clk);
        chk("m5.wen_cleared", o_wen(), 0);
        chk("m5.rn_low", o_rn(), 0);
        chk("m5.busy", o_busy(), 1);
        chk("m5.mem0", memv(60), 32'hA5);
        chk("m5.mem1", memv(61), 0);
        boot("m5", 24);
        chk("m5.cold", o_cold(), 1);
        chk_sig("m5");

        // 6: request held during RD/CMP/WR_SIG/PULSE is ignored
        reset_and_load("i6", 0, -1);
        req = 1'b1;
        boot("i6", 22);
        repeat (3) @(negedge clk);
        chk("i6.stay_run", o_rn(), 1);
        chk("i6.cnt", o_cnt(), 1);
        chk("a.overlap", ovl_a, 0);

        // 6: wide instance, cold then warm
        sel = 1'b1;
        reset_and_load("bc", 0, -1);
        r0 = rdc(); w0 = wrc();
        boot("bc", 26);
        chk("bc.reads", rdc() - r0, 1);
        chk("bc.writes", wrc() - w0, 8);
        chk_sig("bc");
        chk("bc.cold", o_cold(), 1);
        chk("bc.cnt", o_cnt(), 1);
        reset_and_load("bw", 1, -1);
        r0 = rdc(); w0 = wrc();
        boot("bw", 17);
        chk("bw.reads", rdc() - r0, 8);
        chk("bw.writes", wrc() - w0, 0);
        chk("bw.cold", o_cold(), 0);
        chk("b.overlap", ovl_b, 0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule

// File: doc/isp_restart_seq.md
Name: isp_restart_seq

Overview:
Parametrised successor to the RAM-interface restart logic used after ISP. On reset release it reads a multi-word boot signature from the on-chip two-port SRAM to classify the boot as cold or warm. On a cold boot it rewrites the signature and stretches a downstream reset for a configurable pulse. It also accepts a runtime restart request. It sits between the TPSRAM macro and the tamper/system blocks that consume o_reset_n.

Parameters:
DATA_W, 8, TPSRAM data width
ADDR_W, 6, TPSRAM address width
SIG_WORDS, 4, number of signature words; range 1..2^ADDR_W-BASE_ADDR
BASE_ADDR, 60 (6'h3C), first signature address
SIG_SEED, 8'hA5, signature seed; word k = SIG_SEED XOR k, with k truncated or zero-extended to DATA_W
RST_PULSE_CYC, 16, downstream reset low time in cycles after a signature write; must be >= 1

Ports:
CLK  in  1  system clock
RESETn  in  1  synchronous active-low reset
i_restart_req  in  1  single-cycle restart request; sampled only in RUN
i_TPSRAM_RD_sv  in  DATA_W  TPSRAM read data, valid the cycle after REN
o_TPSRAM_WADDR_sv  out  ADDR_W  write address
o_TPSRAM_RADDR_sv  out  ADDR_W  read address
o_TPSRAM_WD  out  DATA_W  write data
o_TPSRAM_WEN  out  1  write enable
o_TPSRAM_REN  out  1  read enable
o_reset_n  out  1  downstream active-low reset
o_busy  out  1  high whenever state != RUN
o_cold_boot  out  1  1 = last classification was cold
o_restart_cnt  out  8  saturating count of cold-path completions

Behaviour:
- Clocking and reset: single clock CLK. RESETn is synchronous and active-low. All outputs are registered.
- Reset values: state IDLE, WEN=0, REN=0, WADDR=RADDR=BASE_ADDR, WD=0, o_reset_n=0, o_busy=1, o_cold_boot=0, o_restart_cnt=0, word counter k=0, pulse counter=0.
- IDLE: 1 cycle. Clear k, then go to RD.
- RD: REN=1, RADDR=BASE_ADDR+k. Go to CMP.
- CMP: REN=0. Compare i_TPSRAM_RD_sv with sig(k).
  - Mismatch: set o_cold_boot=1, clear k, go to WR_SIG. Remaining words are not read.
  - Match and k<SIG_WORDS-1: k++, go to RD.
  - Match and last word: set o_cold_boot=0, go to RUN. This is the warm path with no pulse.
- WR_SIG: one word per cycle. WEN=1, WADDR=BASE_ADDR+k, WD=sig(k). After the last word, drop WEN and go to PULSE. Takes SIG_WORDS cycles.
- PULSE: hold o_reset_n=0 for exactly RST_PULSE_CYC cycles. Then increment o_restart_cnt (saturates at 255) and go to RUN.
- RUN: o_reset_n=1, o_busy=0. On i_restart_req=1: set o_reset_n=0 on the next edge and go to CLR_SIG.
- CLR_SIG: write 0 to all SIG_WORDS addresses, one per cycle. Then go to IDLE. The re-check that follows takes the cold path.
- o_reset_n stays 0 in every state except RUN.
- Warm latency: o_reset_n rises 1+2*SIG_WORDS cycles after RESETn is first sampled high (9 at defaults).
- Cold latency: o_reset_n rises 2+2m+SIG_WORDS+RST_PULSE_CYC cycles after release, where m is the 0-based index of the first mismatching word. Corrupt word 0 at defaults gives 22.
- WEN and REN are never high in the same cycle.
- i_restart_req outside RUN is ignored and not queued.
- RESETn low in any state, including mid-write or mid-pulse, returns the block to reset values on the next edge.
  - A partially written signature is not repaired; the next check classifies it.
  - o_restart_cnt is also cleared by reset.
- Address arithmetic is ADDR_W bits. Parameter legality guarantees no wrap; an assertion in the bench checks BASE_ADDR+SIG_WORDS <= 2^ADDR_W.

Test Plan:
1. Cold boot, RAM all 0x00, defaults -> one read at 0x3C; writes 0x3C:A5, 0x3D:A4, 0x3E:A7, 0x3F:A6; o_reset_n low 16 cycles in PULSE, rising at cycle 22; o_cold_boot=1; o_restart_cnt=1.
2. Warm boot, RAM preloaded A5/A4/A7/A6 -> four reads, no WEN; o_reset_n rises at cycle 9; o_cold_boot=0; o_restart_cnt=0.
3. Partial corruption, 0x3E=0x00 -> reads 0x3C, 0x3D, 0x3E only; full four-word rewrite; o_cold_boot=1.
4. In RUN, pulse i_restart_req -> o_reset_n=0 next cycle; zeros written to 0x3C..0x3F; re-check goes cold; o_restart_cnt increments by 1.
5. RESETn low for 1 cycle during the second WR_SIG write -> next edge WEN=0, o_reset_n=0; after release, 0x3C matches and 0x3D mismatches, so the block goes cold.
6. i_restart_req asserted during RD, PULSE and CLR_SIG -> no effect; sequence timing unchanged. Run with DATA_W=16, ADDR_W=10, SIG_WORDS=8 and repeat scenarios 1-2.
